// File: rtl/tick_period_monitor.sv
// Half-period checker for a toggling divider output: measures clk cycles between
// edges, flags out-of-tolerance periods, tracks lock and detects a stuck input.
module tick_period_monitor #(
  parameter int CNT_W       = 16,
  parameter int EXPECT_HALF = 6000,
  parameter int TOL         = 4,
  parameter int LOCK_COUNT  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  output logic [CNT_W-1:0] half_period,
  output logic             period_valid,
  output logic             in_range,
  output logic             locked,
  output logic             timeout
);

  localparam int HI_LIM = EXPECT_HALF + TOL;
  localparam int LO_LIM = (EXPECT_HALF > TOL) ? (EXPECT_HALF - TOL) : 0;
  localparam int RUN_W  = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W:0]   HI_W    = (CNT_W + 1)'(HI_LIM);
  localparam logic [CNT_W:0]   LO_W    = (CNT_W + 1)'(LO_LIM);
  localparam logic [CNT_W-1:0] HI_C    = CNT_W'(HI_LIM);
  localparam logic [CNT_W-1:0] SAT_C   = CNT_W'(HI_LIM + 1);
  localparam logic [RUN_W-1:0] LOCK_C  = RUN_W'(LOCK_COUNT);

  localparam logic [0:0] SEARCH = 1'b0;
  localparam logic [0:0] TRACK  = 1'b1;

  logic             sig_d;
  logic [CNT_W-1:0] cnt;
  logic [RUN_W-1:0] run;
  logic [0:0]       state;

  logic             edge_det;
  logic [CNT_W:0]   cnt_ext;
  logic             meas_ok;
  logic [RUN_W-1:0] run_inc;

  always_comb begin
    edge_det = sig_in ^ sig_d;
    cnt_ext  = {1'b0, cnt};
    meas_ok  = (cnt_ext >= LO_W) && (cnt_ext <= HI_W);
    run_inc  = (run == LOCK_C) ? run : run + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // Track the input during reset so release never looks like an edge.
      sig_d        <= sig_in;
      cnt          <= '0;
      run          <= '0;
      state        <= SEARCH;
      half_period  <= '0;
      period_valid <= 1'b0;
      in_range     <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      sig_d        <= sig_in;
      period_valid <= 1'b0;

      if (edge_det) begin
        cnt <= CNT_W'(1);
      end else if (cnt != SAT_C) begin
        cnt <= cnt + 1'b1;
      end

      if (state == SEARCH) begin
        if (edge_det) begin
          state   <= TRACK;
          timeout <= 1'b0;
        end
      end else begin
        if (edge_det) begin
          half_period  <= cnt;
          period_valid <= 1'b1;
          in_range     <= meas_ok;
          if (meas_ok) begin
            run    <= run_inc;
            locked <= (run_inc == LOCK_C);
          end else begin
            run    <= '0;
            locked <= 1'b0;
          end
        end else if (cnt == HI_C) begin
          // Stuck input: drop lock and re-arm on the next edge.
          timeout <= 1'b1;
          locked  <= 1'b0;
          run     <= '0;
          state   <= SEARCH;
        end
      end
    end
  end

endmodule

// File: tb/tb_tick_period_monitor.sv
// Randomized bench for tick_period_monitor against an edge-timestamp reference model.
module tb_tick_period_monitor;

  localparam int CW = 16;
  localparam int EH = 60;
  localparam int TL = 4;
  localparam int LC = 3;
  localparam int HI = EH + TL;
  localparam int LO = EH - TL;

  logic          clk;
  logic          reset;
  logic          sig_in;
  logic [CW-1:0] half_period;
  logic          period_valid;
  logic          in_range;
  logic          locked;
  logic          timeout;

  tick_period_monitor #(
    .CNT_W(CW), .EXPECT_HALF(EH), .TOL(TL), .LOCK_COUNT(LC)
  ) dut (
    .clk(clk), .reset(reset), .sig_in(sig_in),
    .half_period(half_period), .period_valid(period_valid),
    .in_range(in_range), .locked(locked), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: timestamps of edges, not counters.
  int          cyc = 0;
  int          last_edge = 0;
  bit          armed = 0;
  int          run_len = 0;
  logic        prev_in = 1'b0;
  logic [CW-1:0] exp_hp = '0;
  logic        exp_pv = 1'b0, exp_in = 1'b0, exp_lk = 1'b0, exp_to = 1'b0;

  function automatic logic [CW+3:0] dut_vec();
    return {half_period, period_valid, in_range, locked, timeout};
  endfunction

  function automatic logic [CW+3:0] exp_vec();
    return {exp_hp, exp_pv, exp_in, exp_lk, exp_to};
  endfunction

  task automatic drive(input logic v, input logic r);
    int n;
    bit e;
    sig_in = v;
    reset  = r;
    @(posedge clk);
    #1;
    cyc++;
    e = (v != prev_in);
    prev_in = v;
    exp_pv = 1'b0;
    if (r) begin
      armed = 0; run_len = 0;
      exp_hp = '0; exp_in = 0; exp_lk = 0; exp_to = 0;
    end else if (e) begin
      if (armed) begin
        n = cyc - last_edge;
        exp_hp = CW'(n);
        exp_pv = 1'b1;
        exp_in = (n >= LO) && (n <= HI);
        if (exp_in) begin
          run_len = (run_len + 1 > LC) ? LC : run_len + 1;
          exp_lk = (run_len == LC);
        end else begin
          run_len = 0;
          exp_lk = 1'b0;
        end
      end else begin
        armed = 1;
        exp_to = 1'b0;
      end
      last_edge = cyc;
    end else if (armed && (cyc - last_edge == HI)) begin
      exp_to = 1'b1; exp_lk = 1'b0; run_len = 0; armed = 0;
    end
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) drive(sig_in, 1'b0);
  endtask

  // Next edge lands exactly n cycles after the previous one.
  task automatic gap(input int n);
    hold(n - 1);
    drive(~sig_in, 1'b0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1);
    n_checks++;
    if (dut_vec() !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected 0", dut_vec());
    end
    drive(1'b0, 1'b0);
    n_checks++;
    if (dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_release: got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_nominal();
    gap($urandom_range(5, 30));
    n_checks++;
    if (period_valid !== 1'b0 || dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL nominal_arm: got %h expected %h", dut_vec(), exp_vec());
    end
    for (int k = 1; k <= 4; k++) begin
      gap(EH);
      n_checks++;
      if (dut_vec() !== exp_vec() || half_period !== CW'(EH) || locked !== (k >= LC)) begin
        n_fail++;
        $display("FAIL nominal_period%0d: got %h expected %h", k, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_tolerance();
    int per[4];
    per = '{LO, HI, LO - 1, HI + 1};
    for (int k = 0; k < 4; k++) begin
      gap(per[k]);
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL tolerance_%0d: got %h expected %h", per[k], dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_timeout();
    for (int k = 0; k < 4; k++) gap($urandom_range(LO, HI));
    hold(HI - 1);
    n_checks++;
    if (timeout !== 1'b0 || locked !== 1'b1 || dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL timeout_early: got %h expected %h", dut_vec(), exp_vec());
    end
    hold(1);
    n_checks++;
    if (timeout !== 1'b1 || locked !== 1'b0 || dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL timeout_fire: got %h expected %h", dut_vec(), exp_vec());
    end
    hold($urandom_range(5, 20));
    drive(~sig_in, 1'b0);
    n_checks++;
    if (timeout !== 1'b0 || period_valid !== 1'b0 || dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL timeout_rearm: got %h expected %h", dut_vec(), exp_vec());
    end
    gap(EH);
    n_checks++;
    if (period_valid !== 1'b1 || half_period !== CW'(EH) || dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL timeout_recover: got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_boundary();
    gap(EH);
    gap(HI);
    n_checks++;
    if (half_period !== CW'(HI) || in_range !== 1'b1 || timeout !== 1'b0 ||
        dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL boundary_hi: got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 4; k++) gap(EH);
    hold(EH / 2);
    drive(~sig_in, 1'b1);
    n_checks++;
    if (dut_vec() !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: got %h expected 0", dut_vec());
    end
    hold(3);
    gap(10);
    n_checks++;
    if (period_valid !== 1'b0 || dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_mid_arm: got %h expected %h", dut_vec(), exp_vec());
    end
    for (int k = 1; k <= 3; k++) begin
      gap($urandom_range(LO, HI));
      n_checks++;
      if (locked !== (k == 3) || dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset_mid_relock%0d: got %h expected %h", k, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_glitch();
    for (int k = 0; k < 3; k++) gap(EH);
    hold(20);
    drive(~sig_in, 1'b0);
    drive(~sig_in, 1'b0);
    n_checks++;
    if (half_period !== CW'(1) || in_range !== 1'b0 || locked !== 1'b0 ||
        dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL glitch: got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    int n;
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 5))
        0:       n = $urandom_range(1, LO - 1);
        1:       n = 1;
        2:       n = HI;
        default: n = $urandom_range(LO, HI);
      endcase
      gap(n);
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random_%0d_gap%0d: got %h expected %h", k, n, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    sig_in = 1'b0;
    test_reset();
    test_nominal();
    test_tolerance();
    test_timeout();
    test_boundary();
    test_reset_mid();
    test_glitch();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
